// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared offsets, defaults and helpers for the button responder
package btn_pkg;

  localparam int DEF_NBTN            = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 20000;
  localparam int DEF_CNT_W           = 8;

  localparam logic [11:0] OFF_STATE = 12'h000;
  localparam logic [11:0] OFF_EDGE  = 12'h004;
  localparam logic [11:0] OFF_COUNT = 12'h008;
  localparam logic [11:0] OFF_MASK  = 12'h00C;
  localparam logic [11:0] OFF_REL   = 12'h010;

  // Register index as seen on addr[4:2]
  typedef enum logic [2:0] {
    REG_STATE = OFF_STATE[4:2],
    REG_EDGE  = OFF_EDGE[4:2],
    REG_COUNT = OFF_COUNT[4:2],
    REG_MASK  = OFF_MASK[4:2],
    REG_REL   = OFF_REL[4:2]
  } btn_reg_e;

  // Bits needed to hold cycles-1, never less than one
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus hold-time debounce for one button
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          sync;
  logic          accept;

  assign sync       = sync_q[1];
  // The new level is accepted on the edge where the count would reach DEBOUNCE_CYCLES
  assign accept     = (sync != stable_q) && (cnt_q == CNT_LAST);
  assign rise_pulse = accept & sync;
  assign fall_pulse = accept & ~sync;
  assign stable     = stable_q;

  // Bring the asynchronous pad level into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], button};
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync == stable_q) begin
      cnt_q <= '0;
    end else if (accept) begin
      stable_q <= sync;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/interface_button_dbnc.sv
// rtl/interface_button_dbnc.sv - button responder: debounce, sticky flags, press counter, irq (option BTN_RELEASE_EDGE_EN)
module interface_button_dbnc
  import btn_pkg::*;
#(
  parameter int NBTN            = DEF_NBTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     addr,
  input  logic            wen,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NBTN-1:0] button,
  output logic            irq
);

  logic [NBTN-1:0]  stable;
  logic [NBTN-1:0]  rise;
  logic [NBTN-1:0]  fall;
  logic [NBTN-1:0]  edge_q;
  logic [NBTN-1:0]  mask_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] press_cnt;
  logic             hit;
  logic [2:0]       sel;
  logic             wr_edge;
  logic             wr_count;
  logic             wr_mask;
  logic             unused_bits;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc (
      .clk       (clk),
      .rst       (rst),
      .button    (button[i]),
      .stable    (stable[i]),
      .rise_pulse(rise[i]),
      .fall_pulse(fall[i])
    );
  end

`ifdef BTN_RELEASE_EDGE_EN
  logic [NBTN-1:0] rel_q;
  logic            wr_rel;

  assign hit         = (addr[11:5] == '0);
  assign sel         = addr[4:2];
  assign wr_rel      = wen && hit && (sel == REG_REL);
  assign irq         = |(edge_q & mask_q) | |(rel_q & mask_q);
  assign unused_bits = ^{addr[1:0], wdata[31:NBTN]};

  // Sticky release flags; a release in the clearing cycle keeps its flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rel_q <= '0;
    else      rel_q <= (rel_q & ~(wr_rel ? wdata[NBTN-1:0] : '0)) | fall;
  end
`else
  assign hit         = (addr[11:4] == '0);
  assign sel         = {1'b0, addr[3:2]};
  assign irq         = |(edge_q & mask_q);
  assign unused_bits = ^{addr[1:0], wdata[31:NBTN], fall};
`endif

  assign wr_edge  = wen && hit && (sel == REG_EDGE);
  assign wr_count = wen && hit && (sel == REG_COUNT);
  assign wr_mask  = wen && hit && (sel == REG_MASK);

  // Number of buttons accepting a press this cycle
  always_comb begin
    press_cnt = '0;
    for (int i = 0; i < NBTN; i++) press_cnt = press_cnt + CNT_W'(rise[i]);
  end

  // Sticky press flags, press counter and interrupt mask
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_q  <= '0;
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      edge_q  <= (edge_q & ~(wr_edge ? wdata[NBTN-1:0] : '0)) | rise;
      count_q <= wr_count ? '0 : count_q + press_cnt;
      if (wr_mask) mask_q <= wdata[NBTN-1:0];
    end
  end

  // Loads return the state as of the last edge; misses and unused bits read 0
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        REG_STATE: rdata[NBTN-1:0]  = stable;
        REG_EDGE:  rdata[NBTN-1:0]  = edge_q;
        REG_COUNT: rdata[CNT_W-1:0] = count_q;
        REG_MASK:  rdata[NBTN-1:0]  = mask_q;
`ifdef BTN_RELEASE_EDGE_EN
        REG_REL:   rdata[NBTN-1:0]  = rel_q;
`endif
        default:   rdata = '0;
      endcase
    end
  end

endmodule
